alu_addsub_pipe: RTL and testbench



---
 rtl/alu_addsub_pipe.sv | 86 ++++++++
 tb/tb_alu_addsub_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: two-stage pipelined add/sub/compare unit with branch resolution and NZCV flags.
module alu_addsub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             is_branch,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             taken,
    output logic             illegal,
    output logic [3:0]       flags
);
    localparam int M = WIDTH - 1;
    logic         s1_valid, s1_c, s1_am, s1_bm, s1_br, s1_es;
    logic [M:0]   s1_diff;
    logic [2:0]   s1_f3;
    logic         s2_adv, s1_adv, accept, es;
    logic [WIDTH:0] s;
    logic         n, z, v, lts, ltu, is_cmp, cond;
    logic [M:0]   res_d;
    logic         taken_d, illegal_d;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = !rst && !flush && s1_adv;
    assign accept   = in_valid && in_ready;
    assign es       = sub | is_branch;
    assign s        = {1'b0, a} + {1'b0, b ^ {WIDTH{es}}} + {{WIDTH{1'b0}}, es};

    always_ff @(posedge clk) begin
        if (rst || flush) s1_valid <= 1'b0;
        else if (s1_adv) s1_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_diff <= s[M:0];
            s1_c    <= s[WIDTH];
            s1_am   <= a[M];
            s1_bm   <= b[M];
            s1_f3   <= funct3;
            s1_br   <= is_branch;
            s1_es   <= es;
        end
    end

    assign n         = s1_diff[M];
    assign z         = s1_diff == '0;
    assign v         = (s1_am ^ s1_bm ^ ~s1_es) & (s1_am ^ s1_diff[M]);
    assign lts       = n ^ v;
    assign ltu       = ~s1_c;
    assign is_cmp    = s1_f3[2:1] == 2'b01;
    assign res_d     = (s1_es && !s1_br && is_cmp) ? {{M{1'b0}}, s1_f3[0] ? ltu : lts} : s1_diff;
    assign illegal_d = s1_br && is_cmp;
    // funct3[0] inverts the base condition selected by funct3[2:1]
    assign cond      = s1_f3[2] ? (s1_f3[1] ? ltu : lts) : z;
    assign taken_d   = s1_br && !is_cmp && (cond ^ s1_f3[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            taken     <= 1'b0;
            illegal   <= 1'b0;
            flags     <= '0;
        end else begin
            if (flush) out_valid <= 1'b0;
            else if (s2_adv) out_valid <= s1_valid;
            if (!flush && s2_adv && s1_valid) begin
                result  <= res_d;
                taken   <= taken_d;
                illegal <= illegal_d;
                flags   <= {n, z, s1_c, v};
            end
        end
    end
endmodule

// File: tb/tb_alu_addsub_pipe.sv
// tb_alu_addsub_pipe: directed stimulus checked every cycle against an arithmetic reference queue.
module tb_alu_addsub_pipe;
    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, sub = 0, is_branch = 0, out_ready = 1;
    logic [2:0]  funct3 = 0;
    logic [31:0] a = 0, b = 0;
    logic        in_ready, out_valid, taken, illegal;
    logic [31:0] result;
    logic [3:0]  flags;

    alu_addsub_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .is_branch(is_branch), .funct3(funct3), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .taken(taken),
        .illegal(illegal), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic        t;
        logic        il;
        logic [3:0]  f;
    } exp_t;
    typedef struct {
        exp_t e;
        int   rdy;
    } ent_t;
    typedef struct {
        logic        s, br;
        logic [2:0]  f;
        logic [31:0] x, y;
    } vec_t;

    ent_t q[$];
    int   pass_cnt = 0, tot_cnt = 0, cyc = 0;
    logic saw_full = 0, prev_stall = 0;
    logic [37:0] prev_out;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic exp_t model(input logic s, input logic br, input logic [2:0] f3,
                                   input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        logic   es, c, vv, lts, ltu;
        logic [31:0] d;
        logic [32:0] wide;
        longint r;
        es   = s | br;
        d    = es ? x - y : x + y;
        wide = {1'b0, x} + {1'b0, y};
        c    = es ? (x >= y) : wide[32];
        r    = es ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
        vv   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        lts  = $signed(x) < $signed(y);
        ltu  = x < y;
        e.f  = {d[31], d == 0, c, vv};
        e.r  = (!br && es && f3 == 3'd2) ? {31'd0, lts} : (!br && es && f3 == 3'd3) ? {31'd0, ltu} : d;
        e.il = br && (f3 == 3'd2 || f3 == 3'd3);
        case (f3)
            3'd0: e.t = br && (x == y);
            3'd1: e.t = br && (x != y);
            3'd4: e.t = br && lts;
            3'd5: e.t = br && !lts;
            3'd6: e.t = br && ltu;
            3'd7: e.t = br && !ltu;
            default: e.t = 1'b0;
        endcase
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, q.size() > 0 && cyc >= q[0].rdy);
            if (out_valid && q.size() > 0) begin
                chk("result", result, q[0].e.r);
                chk("taken", taken, q[0].e.t);
                chk("illegal", illegal, q[0].e.il);
                chk("flags", flags, q[0].e.f);
            end
            if (out_valid && q.size() == 0) chk("extra_output", 1, 0);
            if (prev_stall) chk("stall_stable", {result, taken, illegal, flags}, prev_out);
            chk("in_ready", in_ready, !flush && !(q.size() == 2 && !out_ready));
            if (!in_ready && !flush) saw_full = 1;
        end else chk("in_ready_rst", in_ready, 0);
        prev_stall = !rst && !flush && out_valid && !out_ready;
        prev_out   = {result, taken, illegal, flags};
        if (rst || flush) q.delete();
        else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back('{model(sub, is_branch, funct3, a, b), cyc + 2});
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic br, input logic [2:0] f,
                        input logic [31:0] x, input logic [31:0] y);
        logic ok;
        ok = 0;
        sub = s; is_branch = br; funct3 = f; a = x; b = y; in_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        sync();
        in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
        sync();
    endtask

    vec_t vecs [0:16] = '{
        '{0, 0, 3'd0, 32'd7, 32'd5}, '{0, 0, 3'd0, 32'hFFFFFFFF, 32'd1},
        '{1, 0, 3'd2, 32'hFFFFFFFF, 32'd1}, '{1, 0, 3'd3, 32'hFFFFFFFF, 32'd1},
        '{1, 0, 3'd0, 32'h80000000, 32'd1}, '{1, 0, 3'd2, 32'h80000000, 32'd1},
        '{0, 0, 3'd2, 32'd3, 32'd4}, '{1, 0, 3'd5, 32'd10, 32'd3},
        '{0, 1, 3'd0, 32'd3, 32'd3}, '{0, 1, 3'd0, 32'd3, 32'hFFFFFFFF},
        '{0, 1, 3'd1, 32'd3, 32'd3}, '{0, 1, 3'd4, 32'd3, 32'hFFFFFFFF},
        '{0, 1, 3'd5, 32'd3, 32'hFFFFFFFF}, '{0, 1, 3'd6, 32'd3, 32'hFFFFFFFF},
        '{0, 1, 3'd7, 32'd3, 32'hFFFFFFFF}, '{0, 1, 3'd2, 32'd3, 32'd3},
        '{1, 1, 3'd3, 32'd3, 32'hFFFFFFFF}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        chk("pin_add", model(0, 0, 3'd0, 32'd7, 32'd5), {32'd12, 2'b00, 4'b0000});
        chk("pin_wrap", model(0, 0, 3'd0, 32'hFFFFFFFF, 32'd1), {32'd0, 2'b00, 4'b0110});
        chk("pin_ovf", model(1, 0, 3'd0, 32'h80000000, 32'd1), {32'h7FFFFFFF, 2'b00, 4'b0011});
        chk("pin_slt_ovf", model(1, 0, 3'd2, 32'h80000000, 32'd1), {32'd1, 2'b00, 4'b0011});
        chk("pin_slt", model(1, 0, 3'd2, 32'hFFFFFFFF, 32'd1), {32'd1, 2'b00, 4'b1010});
        chk("pin_sltu", model(1, 0, 3'd3, 32'hFFFFFFFF, 32'd1), {32'd0, 2'b00, 4'b1010});
        chk("pin_beq", model(0, 1, 3'd0, 32'd3, 32'd3), {32'd0, 2'b10, 4'b0110});
        chk("pin_blt", model(0, 1, 3'd4, 32'd3, 32'hFFFFFFFF), {32'd4, 2'b00, 4'b0000});
        chk("pin_bltu", model(0, 1, 3'd6, 32'd3, 32'hFFFFFFFF), {32'd4, 2'b10, 4'b0000});
        chk("pin_illegal", model(0, 1, 3'd2, 32'd3, 32'd3), {32'd0, 2'b01, 4'b0110});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {result, taken, illegal, flags}, 0);
        sync();
        rst = 0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        sync();

        foreach (vecs[i]) send(vecs[i].s, vecs[i].br, vecs[i].f, vecs[i].x, vecs[i].y);
        drain();

        saw_full = 0;
        fork
            for (int i = 1; i <= 4; i++) send(0, 0, 3'd0, i, i);
            begin
                for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
                sync();
                out_ready = 0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        chk("in_ready_fell", saw_full, 1);

        send(0, 0, 3'd0, 32'd10, 32'd20);
        send(1, 0, 3'd0, 32'd10, 32'd20);
        sub = 0; a = 32'd99; b = 32'd1; in_valid = 1; flush = 1;
        @(negedge clk);
        chk("flush_no_accept", in_ready, 0);
        sync();
        flush = 0; in_valid = 0;
        repeat (4) begin
            @(negedge clk);
            chk("flush_killed", out_valid, 0);
        end
        sync();
        send(0, 0, 3'd0, 32'd40, 32'd2);
        drain();

        send(0, 0, 3'd0, 32'd5, 32'd6);
        send(1, 1, 3'd1, 32'd5, 32'd6);
        in_valid = 1; rst = 1;
        sync();
        rst = 0; in_valid = 0;
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_outputs", {result, taken, illegal, flags}, 0);
        sync();
        send(1, 0, 3'd3, 32'd1, 32'd2);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
